// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller state
// encoding and the legal operand width range.
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int SERIAL_MIN_WIDTH = 2;
    localparam int SERIAL_MAX_WIDTH = 64;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor cell (a - b - bin), the mirror of the
// full adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b, LSB first, one bit per clock.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state    | meaning
// ST_IDLE  | ready, waiting for start
// ST_SHIFT | one full-subtractor step per clock, WIDTH steps
// ST_DONE  | one-cycle done pulse, result registers valid
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < SERIAL_MIN_WIDTH || WIDTH > SERIAL_MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             d_bit;
    logic             bo_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bor),
        .diff (d_bit),
        .bout (bo_bit)
    );

    // Result fills from the top so that after WIDTH shifts bit 0 holds the LSB.
    assign r_next = {d_bit, r_sh[WIDTH-1:1]};

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SHIFT);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        bor   <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sh <= r_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bor  <= bo_bit;
                    cnt  <= cnt + CW'(1);
                    // Publish on the last step so the result is valid throughout DONE.
                    if (cnt == LAST) begin
                        diff   <= r_next;
                        borrow <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances),
// scoreboard of expected results; covers ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b, diff;
    logic          ready, busy, done, borrow;
    logic          start2;
    logic [W2-1:0] a2, b2, diff2;
    logic          ready2, busy2, done2, borrow2;
`ifdef SERIAL_SUB_OVF_EN
    logic          ovf, ovf2;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .borrow(borrow)
    );

    serial_subtractor #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .ready(ready2), .busy(busy2), .done(done2), .diff(diff2),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf2),
`endif
        .borrow(borrow2)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W2-1:0] d;
        logic          bo;
    } exp2_t;

    exp_t  sb[$];
    exp2_t sb2[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic exp_t model8(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.bo = (av < bv);
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    // Drives one WIDTH=8 operation from IDLE and returns what the DUT produced.
    task automatic do_op8(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] od, output logic ob, output logic oov,
                          output int lat, output logic hold_ok, output logic rdy_ok,
                          output logic pulse_ok);
        logic [W-1:0] d0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        sb.push_back(model8(av, bv));
        d0 = diff;
        @(negedge clk);
        start = 1'b0; a = ~av; b = W'($urandom);
        lat = -1; hold_ok = 1'b1;
        rdy_ok = (ready === 1'b0);
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (diff !== d0) hold_ok = 1'b0;
            if (ready !== 1'b0) rdy_ok = 1'b0;
        end
        od = diff; ob = borrow;
`ifdef SERIAL_SUB_OVF_EN
        oov = ovf;
`else
        oov = 1'b0;
`endif
        @(negedge clk);
        pulse_ok = (done === 1'b0);
    endtask

    task automatic test_reset;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (diff !== '0) $display("FAIL reset_diff: got %h want 00", diff); else n_pass++;
        n_checks++; if (borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", ready); else n_pass++;
    endtask

    task automatic test_basic;
        logic [W-1:0] od; logic ob, oov, hold_ok, rdy_ok, pulse_ok; int lat; exp_t e;
        do_op8(8'd100, 8'd37, od, ob, oov, lat, hold_ok, rdy_ok, pulse_ok);
        e = sb.pop_front();
        n_checks++; if (lat !== W) $display("FAIL basic_latency: got %0d edges want %0d", lat, W); else n_pass++;
        n_checks++; if (od !== e.d) $display("FAIL basic_diff: got %h want %h", od, e.d); else n_pass++;
        n_checks++; if (ob !== e.bo) $display("FAIL basic_borrow: got %b want %b", ob, e.bo); else n_pass++;
        n_checks++; if (hold_ok !== 1'b1) $display("FAIL basic_diff_hold: got changed want held"); else n_pass++;
        n_checks++; if (rdy_ok !== 1'b1) $display("FAIL basic_ready_low: got high want low"); else n_pass++;
        n_checks++; if (pulse_ok !== 1'b1) $display("FAIL basic_done_pulse: got 2+ cycles want 1"); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
        n_checks++; if (oov !== e.ov) $display("FAIL basic_ovf: got %b want %b", oov, e.ov); else n_pass++;
`endif
    endtask

    task automatic test_boundaries;
        logic [W-1:0] av[4];
        logic [W-1:0] bv[4];
        logic [W-1:0] od; logic ob, oov, hold_ok, rdy_ok, pulse_ok; int lat; exp_t e;
        av = '{8'd5, 8'h00, 8'hA5, 8'h5A};
        bv = '{8'd9, 8'hFF, 8'hA5, 8'h00};
        for (int i = 0; i < 4; i++) begin
            do_op8(av[i], bv[i], od, ob, oov, lat, hold_ok, rdy_ok, pulse_ok);
            e = sb.pop_front();
            n_checks++; if (lat !== W) $display("FAIL bnd%0d_latency: got %0d want %0d", i, lat, W); else n_pass++;
            n_checks++; if (od !== e.d) $display("FAIL bnd%0d_diff: got %h want %h", i, od, e.d); else n_pass++;
            n_checks++; if (ob !== e.bo) $display("FAIL bnd%0d_borrow: got %b want %b", i, ob, e.bo); else n_pass++;
        end
    endtask

    // Start held high with new operands every cycle; accepts only in IDLE,
    // i.e. at cycles 0, W+2, 2(W+2), with done W cycles after each accept.
    task automatic test_back_to_back;
        int acc_next = 0;
        int done_due = -1;
        int done_err = 0;
        logic [W-1:0] av, bv;
        exp_t e;
        for (int n = 0; n <= 2 * (W + 2) + W + 1; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if ((done === 1'b1) != (n == done_due)) done_err++;
                if (n == done_due) begin
                    e = sb.pop_front();
                    n_checks++; if (diff !== e.d) $display("FAIL b2b_diff@%0d: got %h want %h", n, diff, e.d); else n_pass++;
                    n_checks++; if (borrow !== e.bo) $display("FAIL b2b_borrow@%0d: got %b want %b", n, borrow, e.bo); else n_pass++;
                end
            end
            if (n < 2 * (W + 2) + W + 1) begin
                av = W'($urandom); bv = W'($urandom);
                a = av; b = bv; start = 1'b1;
                if (n == acc_next && n <= 2 * (W + 2)) begin
                    sb.push_back(model8(av, bv));
                    done_due = n + W + 1;
                    acc_next = n + W + 2;
                end
            end else begin
                start = 1'b0;
            end
        end
        n_checks++; if (done_err != 0) $display("FAIL b2b_done_timing: got %0d bad cycles want 0", done_err); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL b2b_queue: got %0d pending want 0", sb.size()); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int seen_done = 0;
        logic [W-1:0] od; logic ob, oov, hold_ok, rdy_ok, pulse_ok; int lat; exp_t e;
        @(negedge clk);
        a = 8'd200; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
        n_checks++; if (diff !== '0) $display("FAIL abort_diff: got %h want 00", diff); else n_pass++;
        n_checks++; if (borrow !== 1'b0) $display("FAIL abort_borrow: got %b want 0", borrow); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        n_checks++; if (seen_done != 0) $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); else n_pass++;
        do_op8(8'd3, 8'd2, od, ob, oov, lat, hold_ok, rdy_ok, pulse_ok);
        e = sb.pop_front();
        n_checks++; if (od !== e.d) $display("FAIL abort_next_diff: got %h want %h", od, e.d); else n_pass++;
        n_checks++; if (lat !== W) $display("FAIL abort_next_latency: got %0d want %0d", lat, W); else n_pass++;
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        logic [W-1:0] od; logic ob, oov, hold_ok, rdy_ok, pulse_ok; int lat; exp_t e;
        av = '{8'h80, 8'h7F};
        bv = '{8'h01, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            do_op8(av[i], bv[i], od, ob, oov, lat, hold_ok, rdy_ok, pulse_ok);
            e = sb.pop_front();
            n_checks++; if (od !== e.d) $display("FAIL ovf%0d_diff: got %h want %h", i, od, e.d); else n_pass++;
            n_checks++; if (ob !== e.bo) $display("FAIL ovf%0d_borrow: got %b want %b", i, ob, e.bo); else n_pass++;
            n_checks++; if (oov !== e.ov) $display("FAIL ovf%0d_ovf: got %b want %b", i, oov, e.ov); else n_pass++;
        end
    endtask
`endif

    task automatic test_width2_sweep;
        exp2_t e;
        int lat;
        logic [W2-1:0] av, bv;
        for (int p = 0; p < 16; p++) begin
            av = W2'(p >> 2); bv = W2'(p);
            @(negedge clk);
            a2 = av; b2 = bv; start2 = 1'b1;
            e.d = av - bv; e.bo = (av < bv);
            sb2.push_back(e);
            @(negedge clk);
            start2 = 1'b0;
            lat = -1;
            for (int i = 1; i <= W2 + 6; i++) begin
                @(negedge clk);
                if (done2 === 1'b1) begin
                    lat = i;
                    break;
                end
            end
            e = sb2.pop_front();
            n_checks++; if (lat !== W2) $display("FAIL w2_latency a=%0d b=%0d: got %0d want %0d", av, bv, lat, W2); else n_pass++;
            n_checks++; if (diff2 !== e.d) $display("FAIL w2_diff a=%0d b=%0d: got %0d want %0d", av, bv, diff2, e.d); else n_pass++;
            n_checks++; if (borrow2 !== e.bo) $display("FAIL w2_borrow a=%0d b=%0d: got %b want %b", av, bv, borrow2, e.bo); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_boundaries;
        test_back_to_back;
        test_abort;
`ifdef SERIAL_SUB_OVF_EN
        test_ovf;
`endif
        test_width2_sweep;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned/two's-complement subtractor computing diff = a - b, LSB first, one full-subtractor step per clock.
- Inverse arithmetic companion to the team's combinational full adder cell.
- Used where area matters more than latency: one 1-bit subtractor cell plus shift registers.
- Start/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- ready  output  1  high in IDLE; start is accepted only when high
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 iff a < b unsigned

Behaviour:
- Reset:
  - Asserting rst_n=0 at any time, including mid-operation, forces state=IDLE, diff=0, borrow=0, done=0, busy=0, ready=1, bit counter=0, and clears the internal shift registers.
  - The partial result is discarded. No done pulse is produced for an aborted operation.
- FSM states:
  - IDLE: ready=1. When start=1 at a clock edge, load a_sh=a, b_sh=b, bor=0, cnt=0, clear the result shift register, and go to SHIFT.
  - SHIFT: busy=1. Each edge does the following:
    - Compute d = a_sh[0]^b_sh[0]^bor and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor).
    - Shift d into the result MSB; the result shifts right.
    - Shift a_sh and b_sh right; bor <= bo; cnt <= cnt+1.
    - When cnt == WIDTH-1 on that edge, go to DONE.
  - DONE: done=1 for exactly one cycle; diff and borrow are updated from the result register and bor. Unconditionally return to IDLE.
- Latency:
  - Start accepted on edge k. SHIFT edges are k+1 .. k+WIDTH. done is high in the cycle following edge k+WIDTH.
  - Total latency is WIDTH+1 cycles; throughput is one op per WIDTH+2 cycles.
- Start while busy or in DONE: ignored, no error flag. The operands in flight are unaffected.
- Changes to a and b after acceptance have no effect.
- diff and borrow hold their last values from DONE until the next DONE or reset. They do not change during SHIFT.
- Counter width is $clog2(WIDTH)+1. There is no wrap inside an operation.
- Boundaries:
  - a == b gives diff=0, borrow=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
  - b=0 gives diff=a, borrow=0.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), the signed two's-complement overflow, updated in DONE alongside diff.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - The operand MSBs are captured at start.
- Undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE; 2-bit encoding)
  - the constant for the minimum legal WIDTH
- Sub-module full_subtractor:
  - Combinational inputs a, b, bin; outputs diff, bout, with the equations above.
  - Instantiated once in the datapath; the mirror of the existing full adder cell.
- The top level holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=8; a=100, b=37, pulse start -> done exactly 9 cycles later; diff=63, borrow=0; ready low during the wait.
- a=5, b=9 -> diff=8'hFC, borrow=1. Then a=0, b=8'hFF -> diff=8'h01, borrow=1. Then a=b=8'hA5 -> diff=0, borrow=0.
- Start held high continuously with new operands each cycle -> only IDLE-sampled starts are taken; ops complete every 10 cycles with the results of the operands captured at each acceptance.
- Assert rst_n=0 on the 4th SHIFT cycle of a=200, b=1 -> all outputs 0 and ready=1 immediately; no done pulse; the next op a=3, b=2 gives diff=1.
- With SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, borrow=0. Then a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, borrow=1.
- WIDTH=2 sweep of all 16 operand pairs -> diff and borrow match the reference model; latency is 3 cycles each.
